// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Width of the nibble index; at least one bit even for a single nibble.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple adder slice with carry-in, built from full-adder cells.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_adder_cin
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;
  assign cout = c[NIBBLE_W];

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract that walks one shared 4-bit slice
// across the operands, least-significant nibble first.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | start_ready high, waiting for operands
// RUN   | one nibble per cycle through the slice, carry kept in carry_reg
// DONE  | res_valid high, result held until the consumer takes it

module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx;

  // Bit offset of the current nibble; the two zero bits multiply by NIBBLE_W.
  logic [IDX_W+1:0]    nib_lsb;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  assign nib_lsb = {idx, 2'b00};
  assign a_nib   = a_reg[nib_lsb +: NIBBLE_W];
  assign b_nib   = b_reg[nib_lsb +: NIBBLE_W];

  nibble_adder_cin u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Controller: sequences nibbles through the slice and owns all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b0;
      res_valid   <= 1'b0;
      result      <= '0;
      carryout    <= 1'b0;
      overflow    <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      carry_reg   <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          start_ready <= 1'b1;
          if (start_valid && start_ready) begin
            // Subtraction is folded in here as a + ~b + 1.
            a_reg       <= op_a;
            b_reg       <= sub ? ~op_b : op_b;
            carry_reg   <= sub;
            idx         <= '0;
            result      <= '0;
            carryout    <= 1'b0;
            overflow    <= 1'b0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          result[nib_lsb +: NIBBLE_W] <= slice_sum;
          carry_reg                   <= slice_cout;
          if (idx == LAST_IDX) begin
            carryout  <= slice_cout;
            overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (slice_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // start_ready rises together with the return to IDLE, never while res_valid is high.
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b0;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        sub = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] result;
  logic        carryout;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carryout    (carryout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, carryout, result}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16:0] full;
    logic [15:0] bb;
    logic        v;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, s};
    v    = (a[15] == bb[15]) && (full[15] != a[15]);
    return {v, full[16], full[15:0]};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!start_ready && n < 20) begin
      step();
      n++;
    end
    if (!start_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] er, input logic ec, input logic ev,
                       input int gap, input int hold);
    int n;
    repeat (gap) step();
    wait_ready();
    op_a = a;
    op_b = b;
    sub  = s;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
    sub  = 1'($urandom);
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    chk("result", 32'(result), 32'(er));
    chk("carryout", 32'(carryout), 32'(ec));
    chk("overflow", 32'(overflow), 32'(ev));
    repeat (hold) step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("valid_drop", 32'(res_valid), 32'd0);
    chk("ready_rise", 32'(start_ready), 32'd1);
  endtask

  initial begin
    logic        seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic [17:0] m;

    // Reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst_start_ready", 32'(start_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carryout", 32'(carryout), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_start_ready", 32'(start_ready), 32'd1);

    // Directed arithmetic
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 2);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, 0);

    // Back-pressure
    wait_ready();
    op_a = 16'h1111;
    op_b = 16'h2222;
    sub  = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    repeat (4) step();
    chk("bp_valid", 32'(res_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      start_valid = ~start_valid;
      step();
      chk("bp_result", 32'(result), 32'h3333);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_ack_valid", 32'(res_valid), 32'd0);
    chk("bp_ack_ready", 32'(start_ready), 32'd1);
    step();
    chk("bp_no_accept", 32'(start_ready), 32'd1);

    // Reset in the 2nd RUN cycle
    wait_ready();
    op_a = 16'hAAAA;
    op_b = 16'h1111;
    sub  = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_start_ready", 32'(start_ready), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_carryout", 32'(carryout), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 0);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      m  = model(ra, rb, rs);
      do_op(ra, rb, rs, m[15:0], m[16], m[17],
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle controller that adds or subtracts two WIDTH-bit two's-complement operands by sequencing one shared 4-bit ripple adder slice, least-significant nibble first. Each cycle it feeds the slice one nibble of each operand and a registered carry, then stores that nibble of the result. Requests and results use valid/ready handshakes. The block is the wide arithmetic front end for requesters that cannot afford a WIDTH-bit combinational adder.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8
- NIBBLES, WIDTH/4, derived; not overridden

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start_valid  in  1  requester presents operands
- start_ready  out  1  block can accept operands
- op_a  in  WIDTH  first operand
- op_b  in  WIDTH  second operand
- sub  in  1  0 = a+b, 1 = a−b
- res_valid  out  1  result fields valid
- res_ready  in  1  consumer accepts result
- result  out  WIDTH  sum or difference, modulo 2^WIDTH
- carryout  out  1  carry out of the MSB (for sub: 1 = no borrow)
- overflow  out  1  signed overflow

## Operation
- States are IDLE, RUN, DONE.
- **IDLE**
  - start_ready=1.
  - On start_valid&start_ready:
    - capture a_reg=op_a and b_reg = sub ? ~op_b : op_b;
    - carry_reg=sub;
    - idx=0; clear result;
    - go to RUN.
- **RUN**
  - start_ready=0 and res_valid=0.
  - Each cycle, the slice computes a_reg[idx] + b_reg[idx] + carry_reg on nibble idx.
  - The slice's 4-bit sum is written to result[4·idx+3:4·idx], and its cout is written to carry_reg.
  - idx increments each cycle.
  - When idx==NIBBLES−1:
    - carryout = slice cout;
    - overflow = (a_reg[MSB]==b_reg[MSB]) && (slice sum[3]!=a_reg[MSB]);
    - go to DONE.
- **DONE**
  - res_valid=1.
  - result, carryout and overflow are held stable.
  - start_valid is ignored.
  - On res_valid&res_ready, go to IDLE.
  - Outputs keep their last values until the next accept.
- Operands are sampled only at accept. Changes on op_a, op_b or sub afterwards have no effect.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.

## Timing
- **Reset** (rst_n low at a rising edge): next state is IDLE. The following are 0: start_ready (it rises once in IDLE with rst_n high), res_valid, result, carryout, overflow, idx, carry_reg.
- **Reset mid-RUN or mid-DONE**: the operation is abandoned and no result is emitted.
- **Latency**: if accepted at edge k, res_valid is high after edge k+NIBBLES (4 cycles for WIDTH=16).
- **Throughput**: one operation per NIBBLES+2 cycles minimum. The IDLE cycle after a result handshake is mandatory, and start_ready is never high in the same cycle as res_valid.
- **Back-pressure**: DONE may persist indefinitely without any output changing.
- **Carry chain**: the slice is purely combinational. The only path from one nibble to the next is through carry_reg, so the critical path is a single 4-bit ripple.
- **idx**: idx is ceil(log2(NIBBLES)) bits and never wraps while in RUN.

## Structure
- **Package `adder_pkg`**:
  - state enum {IDLE, RUN, DONE};
  - constant NIBBLE_W=4;
  - helper function giving the idx width from NIBBLES.
- **Sub-module `nibble_adder_cin`**:
  - 4-bit ripple adder with carry-in and cout, built from the team's structural full-adder cell;
  - instantiated once and driven by the controller's nibble muxes.
- **Top**: FSM, operand registers, carry_reg, idx counter and result register.

## Test plan
All scenarios use WIDTH=16.
- **Basic add**: accept 0x00FF+0x0001, sub=0 → result 0x0100, carryout 0, overflow 0. res_valid rises exactly 4 cycles after accept.
- **Signed overflow**: 0x7FFF+0x0001 → 0x8000, overflow 1, carryout 0. Then 0xFFFF+0x0001 → 0x0000, carryout 1, overflow 0.
- **Subtract**: 0x0005−0x0007 → 0xFFFE, carryout 0, overflow 0. Then 0x8000−0x0001 → 0x7FFF, carryout 1, overflow 1.
- **Back-pressure**: hold res_ready=0 for 10 cycles and toggle op_a, op_b and start_valid meanwhile → result unchanged, start_ready stays 0, no new accept. Raise res_ready → handshake, then start_ready=1 on the following cycle.
- **Reset mid-operation**: pull rst_n low during the 2nd RUN cycle → after that edge the FSM is in IDLE, all outputs are 0 and res_valid never pulses. The next operation computes 0x1234+0x4321=0x5555 correctly.
- **Random sweep**: 1,000 random op_a/op_b/sub with random start_valid/res_ready gaps, checked against a reference model for result, carryout and overflow.
